// File: rtl/hc4_boot_ctrl.sv
// Boot/run controller for the hc4 core: streams the program ROM image in,
// holds the core in reset for a fixed time, then provides run/halt/step control.
module hc4_boot_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_nreset,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HOLD = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

  typedef struct packed {
    logic [2:0]        state;
    logic              cpu_nreset;
    logic              cpu_en;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_wdata;
    logic [ADDR_W:0]   load_count;
    logic              err;
    logic [3:0]        hold_cnt;
  } ctrl_t;

  ctrl_t cur, nxt;
  logic  step_q;
  logic  step_rise;
  logic  xfer;
  logic  last_slot;

  assign in_ready   = (cur.state == LOAD);
  assign xfer       = in_valid & in_ready;
  assign step_rise  = step_req & ~step_q;
  // load_count doubles as the write address; the final ROM slot ends the load
  assign last_slot  = &cur.load_count[ADDR_W-1:0];

  always_comb begin
    nxt        = cur;
    nxt.rom_we = 1'b0;
    case (cur.state)
      IDLE: begin
        nxt.cpu_nreset = 1'b0;
        nxt.cpu_en     = 1'b0;
        if (load_req) begin
          nxt.state      = LOAD;
          nxt.load_count = '0;
          nxt.err        = 1'b0;
        end else if (!halt_req && run_req) begin
          nxt.state    = HOLD;
          nxt.hold_cnt = '0;
        end
      end
      LOAD: begin
        nxt.cpu_nreset = 1'b0;
        nxt.cpu_en     = 1'b0;
        if (xfer) begin
          nxt.rom_we     = 1'b1;
          nxt.rom_addr   = cur.load_count[ADDR_W-1:0];
          nxt.rom_wdata  = in_data;
          nxt.load_count = cur.load_count + 1'b1;
          if (in_last || last_slot) begin
            nxt.state    = HOLD;
            nxt.hold_cnt = '0;
            nxt.err      = ~in_last;
          end
        end
      end
      HOLD: begin
        nxt.cpu_nreset = 1'b0;
        nxt.cpu_en     = 1'b0;
        if (load_req) begin
          nxt.state      = LOAD;
          nxt.load_count = '0;
          nxt.err        = 1'b0;
          nxt.hold_cnt   = '0;
        end else if (cur.hold_cnt == HOLD_LAST) begin
          nxt.state      = RUN;
          nxt.cpu_nreset = 1'b1;
          nxt.cpu_en     = 1'b1;
        end else begin
          nxt.hold_cnt = cur.hold_cnt + 4'd1;
        end
      end
      RUN: begin
        nxt.cpu_nreset = 1'b1;
        nxt.cpu_en     = 1'b1;
        if (load_req) begin
          nxt.state      = LOAD;
          nxt.load_count = '0;
          nxt.err        = 1'b0;
          nxt.cpu_nreset = 1'b0;
          nxt.cpu_en     = 1'b0;
        end else if (halt_req) begin
          nxt.state  = HALT;
          nxt.cpu_en = 1'b0;
        end
      end
      HALT: begin
        nxt.cpu_nreset = 1'b1;
        nxt.cpu_en     = 1'b0;
        if (load_req) begin
          nxt.state      = LOAD;
          nxt.load_count = '0;
          nxt.err        = 1'b0;
          nxt.cpu_nreset = 1'b0;
        end else if (halt_req) begin
          nxt.state = HALT;
        end else if (run_req) begin
          nxt.state  = RUN;
          nxt.cpu_en = 1'b1;
        end else if (step_rise) begin
          // single-cycle enable lets the core retire exactly one instruction
          nxt.cpu_en = 1'b1;
        end
      end
      default: begin
        nxt.state      = IDLE;
        nxt.cpu_nreset = 1'b0;
        nxt.cpu_en     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cur    <= '0;
      step_q <= 1'b0;
    end else begin
      cur    <= nxt;
      step_q <= step_req;
    end
  end

  assign state      = cur.state;
  assign cpu_nreset = cur.cpu_nreset;
  assign cpu_en     = cur.cpu_en;
  assign rom_we     = cur.rom_we;
  assign rom_addr   = cur.rom_addr;
  assign rom_wdata  = cur.rom_wdata;
  assign load_count = cur.load_count;
  assign err        = cur.err;

endmodule

// File: tb/tb_hc4_boot_ctrl.sv
// Directed bench for hc4_boot_ctrl: load, hold, run/halt/step, overflow, reset mid-load.
module tb_hc4_boot_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic              clk = 1'b0;
  logic              nReset;
  logic              load_req, run_req, halt_req, step_req;
  logic              in_valid, in_last;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, rom_we, cpu_nreset, cpu_en, err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic [2:0]        state;
  logic [ADDR_W:0]   load_count;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int base;
  int en_hi;

  hc4_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(4)) dut (
    .clk(clk), .nReset(nReset),
    .load_req(load_req), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_nreset(cpu_nreset), .cpu_en(cpu_en), .state(state),
    .load_count(load_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rom_we) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_nrst"},  32'(cpu_nreset), 0);
    chk({tag, "_en"},    32'(cpu_en), 0);
    chk({tag, "_rdy"},   32'(in_ready), 0);
    chk({tag, "_we"},    32'(rom_we), 0);
    chk({tag, "_addr"},  32'(rom_addr), 0);
    chk({tag, "_wdata"}, 32'(rom_wdata), 0);
    chk({tag, "_cnt"},   32'(load_count), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  initial begin
    nReset = 1'b0; load_req = 0; run_req = 0; halt_req = 0; step_req = 0;
    in_valid = 0; in_last = 0; in_data = '0;
    #1;
    chk_reset_vals("rst");
    tick(); tick();
    nReset = 1'b1;
    tick();
    chk("idle_state", 32'(state), 32'(S_IDLE));

    // basic 3-byte load
    load_req = 1; tick(); load_req = 0;
    chk("load_state", 32'(state), 32'(S_LOAD));
    chk("load_rdy", 32'(in_ready), 1);
    in_valid = 1; in_data = 8'hA5; tick();
    chk("b0_we", 32'(rom_we), 1); chk("b0_addr", 32'(rom_addr), 0); chk("b0_d", 32'(rom_wdata), 32'hA5);
    in_data = 8'h1F; tick();
    chk("b1_we", 32'(rom_we), 1); chk("b1_addr", 32'(rom_addr), 1); chk("b1_d", 32'(rom_wdata), 32'h1F);
    in_data = 8'hE0; in_last = 1; tick();
    chk("b2_we", 32'(rom_we), 1); chk("b2_addr", 32'(rom_addr), 2); chk("b2_d", 32'(rom_wdata), 32'hE0);
    chk("b2_cnt", 32'(load_count), 3);
    chk("b2_state", 32'(state), 32'(S_HOLD));
    chk("b2_rdy", 32'(in_ready), 0);
    in_valid = 0; in_last = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_state", 32'(state), 32'(S_HOLD));
      chk("hold_nrst", 32'(cpu_nreset), 0);
      chk("hold_we", 32'(rom_we), 0);
    end
    tick();
    chk("run_state", 32'(state), 32'(S_RUN));
    chk("run_nrst", 32'(cpu_nreset), 1);
    chk("run_en", 32'(cpu_en), 1);

    // gapped 4-byte load entered from RUN
    load_req = 1; tick(); load_req = 0;
    chk("g_state", 32'(state), 32'(S_LOAD));
    chk("g_cnt0", 32'(load_count), 0);
    chk("g_nrst", 32'(cpu_nreset), 0);
    chk("g_en", 32'(cpu_en), 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'(8'h10 + i); in_last = (i == 3);
      tick();
      chk("g_we", 32'(rom_we), 1);
      chk("g_addr", 32'(rom_addr), 32'(i));
      chk("g_data", 32'(rom_wdata), 32'(8'h10 + i));
      in_valid = 0; in_last = 0;
      tick();
      chk("g_gap_we", 32'(rom_we), 0);
    end
    chk("g_cnt", 32'(load_count), 4);
    chk("g_hold", 32'(state), 32'(S_HOLD));
    for (int i = 0; i < 3; i++) tick();
    chk("g_run", 32'(state), 32'(S_RUN));

    // halt, held step, resume
    halt_req = 1; tick(); halt_req = 0;
    chk("h_state", 32'(state), 32'(S_HALT));
    chk("h_en", 32'(cpu_en), 0);
    chk("h_nrst", 32'(cpu_nreset), 1);
    step_req = 1; en_hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_en) en_hi++;
      chk("s_state", 32'(state), 32'(S_HALT));
    end
    step_req = 0;
    chk("s_pulses", 32'(en_hi), 1);
    tick();
    chk("s_idle_en", 32'(cpu_en), 0);
    run_req = 1; tick(); run_req = 0;
    chk("r_state", 32'(state), 32'(S_RUN));
    chk("r_en", 32'(cpu_en), 1);

    // halt and load together: load wins
    halt_req = 1; load_req = 1; tick(); halt_req = 0; load_req = 0;
    chk("p_state", 32'(state), 32'(S_LOAD));
    chk("p_nrst", 32'(cpu_nreset), 0);
    chk("p_cnt", 32'(load_count), 0);

    // overflow: 4096 bytes without in_last
    base = wr_cnt;
    in_valid = 1;
    for (int i = 0; i < 4096; i++) begin
      in_data = 8'(i);
      tick();
    end
    chk("o_we", 32'(rom_we), 1);
    chk("o_addr", 32'(rom_addr), 32'hFFF);
    chk("o_data", 32'(rom_wdata), 32'hFF);
    chk("o_err", 32'(err), 1);
    chk("o_cnt", 32'(load_count), 4096);
    chk("o_state", 32'(state), 32'(S_HOLD));
    chk("o_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("o_post_we", 32'(rom_we), 0);
      chk("o_post_addr", 32'(rom_addr), 32'hFFF);
      chk("o_post_err", 32'(err), 1);
    end
    in_valid = 0;
    tick();
    chk("o_wr_total", 32'(wr_cnt - base), 4096);

    // reset in the middle of a load
    load_req = 1; tick(); load_req = 0;
    chk("m_state", 32'(state), 32'(S_LOAD));
    chk("m_err_clr", 32'(err), 0);
    in_valid = 1; in_data = 8'h33; tick();
    in_data = 8'h44; tick();
    chk("m_addr1", 32'(rom_addr), 1);
    chk("m_cnt2", 32'(load_count), 2);
    #3 nReset = 1'b0;
    in_valid = 0;
    #1;
    chk_reset_vals("mrst");
    tick();
    nReset = 1'b1;
    tick();
    load_req = 1; tick(); load_req = 0;
    in_valid = 1; in_data = 8'h5A; in_last = 1; tick();
    in_valid = 0; in_last = 0;
    chk("n_we", 32'(rom_we), 1);
    chk("n_addr", 32'(rom_addr), 0);
    chk("n_data", 32'(rom_wdata), 32'h5A);
    chk("n_cnt", 32'(load_count), 1);
    chk("n_state", 32'(state), 32'(S_HOLD));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc4_boot_ctrl.md
Name: hc4_boot_ctrl

Overview:
Boot and run controller for the hc4 4-bit core.
- Loads the core's 4096x8 program ROM from a byte stream (valid/ready).
- Holds the core in reset while loading, then releases it after a fixed hold time.
- Provides run, halt and single-step control through a core clock-enable.
- Sits between the host/debug interface and the hc4 core plus its ROM write port.

Parameters:
ADDR_W, 12, ROM address width (4096 entries)
DATA_W, 8, ROM word width
RESET_HOLD, 4, cycles cpu_nreset stays low after load before RUN (1..15)

Ports:
clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
load_req  in  1  start a ROM load (level sampled each cycle)
run_req  in  1  release/resume the core
halt_req  in  1  stop the core
step_req  in  1  one-instruction step while halted
in_valid  in  1  stream byte valid
in_data  in  DATA_W  stream byte
in_last  in  1  marks final byte of image
in_ready  out  1  controller accepts byte this cycle
rom_we  out  1  ROM write strobe
rom_addr  out  ADDR_W  ROM write address
rom_wdata  out  DATA_W  ROM write data
cpu_nreset  out  1  active-low reset to core
cpu_en  out  1  core clock-enable (core updates pc/state only when 1)
state  out  3  IDLE=0, LOAD=1, HOLD=2, RUN=3, HALT=4
load_count  out  ADDR_W+1  bytes written in last/current load
err  out  1  sticky overflow: 4096 bytes accepted without in_last

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE, cpu_nreset=0, cpu_en=0, in_ready=0.
  - rom_we=0, rom_addr=0, rom_wdata=0, load_count=0, err=0, hold counter=0.
- All outputs are registered, except in_ready, which is decoded from state (1 only in LOAD).
- Request priority when several are high in one cycle: load_req > halt_req > run_req > step_req.
- IDLE: core held in reset, cpu_en=0.
  - load_req -> LOAD.
  - Else run_req -> HOLD (boot existing ROM contents).
- Entering LOAD (from any state):
  - Internal write address and load_count clear to 0; err clears.
  - cpu_nreset=0 and cpu_en=0 from the next edge.
- LOAD: a byte transfers when in_valid & in_ready.
  - On the edge after a transfer: rom_we=1 for exactly one cycle, rom_addr=address of that byte, rom_wdata=byte. Write latency is 1 cycle.
  - Write address then increments by 1; load_count increments by 1.
  - No transfer -> rom_we=0.
  - Back-to-back transfers give one write per cycle.
  - Transfer with in_last=1 -> HOLD next edge; in_ready drops in that same next cycle.
  - 4096th transfer without in_last -> err=1, HOLD next edge. The address never wraps and no 4097th byte is accepted.
  - load_req, run_req, halt_req and step_req are ignored in LOAD; a load only ends via in_last or overflow.
- HOLD: cpu_nreset=0, cpu_en=0; counter counts RESET_HOLD cycles.
  - Then -> RUN, with cpu_nreset=1 and cpu_en=1 on the same edge.
  - load_req during HOLD -> LOAD (counter cleared).
- RUN: cpu_nreset=1, cpu_en=1.
  - halt_req -> HALT; cpu_en=0 from the next edge.
  - load_req -> LOAD.
- HALT: cpu_nreset=1, cpu_en=0. Core state is preserved.
  - step_req rising edge (internally detected; reset value of the edge register 0) -> cpu_en=1 for exactly one cycle, state stays HALT. A held step_req gives only one step.
  - run_req -> RUN.
  - load_req -> LOAD.
- load_count holds its final value until the next LOAD entry.
- Reset mid-load: all outputs return to reset values immediately. The partial image is not erased, and the address restarts at 0 on the next load.

Test Plan:
- Reset, load_req pulse, stream 3 bytes 0xA5, 0x1F, 0xE0 (in_last on 3rd), in_valid continuous -> rom_we high 3 consecutive cycles at addr 0, 1, 2 with those data; load_count=3; state HOLD; cpu_nreset rises exactly RESET_HOLD=4 cycles later with cpu_en=1, state=RUN.
- In LOAD, toggle in_valid every other cycle for 4 bytes -> rom_we asserted only on the cycles after accepted transfers; addresses 0..3 with no gaps; load_count=4.
- Stream 4096 bytes with in_last never set -> err=1 after the 4096th; last write at addr 0xFFF; in_ready=0 thereafter; no write to addr 0.
- In RUN, assert halt_req -> cpu_en=0 next cycle, state=HALT. Hold step_req high 5 cycles -> cpu_en=1 for exactly 1 cycle. run_req -> cpu_en=1, state=RUN.
- Same cycle halt_req=1 and load_req=1 in RUN -> state=LOAD, cpu_nreset=0 next cycle, load_count=0.
- Drop nReset during LOAD after 2 bytes -> outputs return to reset values asynchronously. New load of 1 byte (in_last) -> write at addr 0, load_count=1.
